// File: rtl/subservient_mem_pkg.sv
// Shared FSM encodings and width helpers for the multi-channel subservient memory controller.
package subservient_mem_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  function automatic int beats_f(input int dw);
    return 32 / dw;
  endfunction

  function automatic int bw_f(input int dw);
    return $clog2(32 / dw);
  endfunction

  function automatic bit sram_dw_legal(input int dw);
    return (dw == 8) || (dw == 16) || (dw == 32);
  endfunction

endpackage

// File: rtl/subservient_rr_arb.sv
// Round-robin grant over N_WB request lines; the channel acked last cycle is held off for one cycle.
module subservient_rr_arb #(
  parameter  int N_WB = 2,
  localparam int IW   = (N_WB > 1) ? $clog2(N_WB) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_WB-1:0] req_i,
  input  logic [N_WB-1:0] ack_i,
  output logic            gnt_vld_o,
  output logic [IW-1:0]   gnt_idx_o
);

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [N_WB-1:0] mask_q;
  int              idx;

  // Scan downwards so the requester closest to the pointer is the last (winning) assignment.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    idx       = 0;
    for (int i = N_WB - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % N_WB;
      if (req_i[idx] && !mask_q[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = IW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < N_WB; i++) begin
      if (ack_i[i]) ptr_d = IW'((i + 1) % N_WB);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      mask_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      mask_q <= ack_i;
    end
  end

endmodule

// File: rtl/subservient_mem_ctrl.sv
// Shares one 1R1W SRAM between the SERV RF port (always wins) and N_WB Wishbone channels.
// Define SUBSERVIENT_RF_PROT_EN to block Wishbone writes into the RF region and flag them.
module subservient_mem_ctrl
  import subservient_mem_pkg::*;
#(
  parameter  int depth    = 512,
  parameter  int SRAM_DW  = 8,
  parameter  int N_WB     = 2,
  parameter  int RF_WORDS = 144,
  localparam int aw       = $clog2(depth)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [aw-1:0]        i_rf_waddr,
  input  logic [SRAM_DW-1:0]   i_rf_wdata,
  input  logic                 i_rf_wen,
  input  logic [aw-1:0]        i_rf_raddr,
  input  logic                 i_rf_ren,
  output logic [SRAM_DW-1:0]   o_rf_rdata,
  input  logic [N_WB*32-1:0]   i_wb_adr,
  input  logic [N_WB*32-1:0]   i_wb_dat,
  input  logic [N_WB*4-1:0]    i_wb_sel,
  input  logic [N_WB-1:0]      i_wb_we,
  input  logic [N_WB-1:0]      i_wb_stb,
  output logic [31:0]          o_wb_rdt,
  output logic [N_WB-1:0]      o_wb_ack,
  output logic [aw-1:0]        o_sram_waddr,
  output logic [SRAM_DW-1:0]   o_sram_wdata,
  output logic [SRAM_DW/8-1:0] o_sram_wmask,
  output logic                 o_sram_wen,
  output logic [aw-1:0]        o_sram_raddr,
  input  logic [SRAM_DW-1:0]   i_sram_rdata,
  output logic                 o_sram_ren,
  output logic                 o_prot_err
);

  localparam int BEATS = beats_f(SRAM_DW);
  localparam int BW    = bw_f(SRAM_DW);
  localparam int BWS   = (BW > 0) ? BW : 1;
  localparam int WA    = aw - BW;
  localparam int MW    = SRAM_DW / 8;
  localparam int IW    = (N_WB > 1) ? $clog2(N_WB) : 1;
  localparam logic [BWS-1:0] LAST_BEAT = BWS'(BEATS - 1);

  if (!sram_dw_legal(SRAM_DW) || N_WB < 1 || N_WB > 4 || RF_WORDS > depth) begin : g_bad_cfg
    $error("subservient_mem_ctrl: illegal parameter combination");
  end

  logic [1:0]         state_q, state_d;
  logic [BWS-1:0]     beat_q, beat_d, cap_beat_q;
  logic [WA-1:0]      adr_q, adr_d;
  logic [31:0]        dat_q, dat_d, rdat_q;
  logic [3:0]         sel_q, sel_d;
  logic               we_q, we_d;
  logic [IW-1:0]      gnt_q, gnt_d, arb_idx;
  logic               arb_vld;
  logic               cap_q, cap_d;
  logic               beat_go, wb_ren, wb_wen, prot_hit;
  logic [aw-1:0]      wb_addr;
  logic [MW-1:0]      lane_sel;
  logic [SRAM_DW-1:0] lane_dat;
  logic               unused_adr;

  assign unused_adr = ^i_wb_adr;

  subservient_rr_arb #(.N_WB(N_WB)) u_arb (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .req_i     (i_wb_stb),
    .ack_i     (o_wb_ack),
    .gnt_vld_o (arb_vld),
    .gnt_idx_o (arb_idx)
  );

  if (BW == 0) begin : g_addr_word
    assign wb_addr = adr_q;
  end else begin : g_addr_beat
    assign wb_addr = {adr_q, beat_q[BW-1:0]};
  end

  assign lane_sel = sel_q[int'(beat_q)*MW +: MW];
  assign lane_dat = dat_q[int'(beat_q)*SRAM_DW +: SRAM_DW];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    gnt_d   = gnt_q;
    beat_go = 1'b0;
    wb_ren  = 1'b0;
    wb_wen  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_vld) begin
          gnt_d   = arb_idx;
          adr_d   = i_wb_adr[int'(arb_idx)*32 + 2 +: WA];
          dat_d   = i_wb_dat[int'(arb_idx)*32 +: 32];
          sel_d   = i_wb_sel[int'(arb_idx)*4 +: 4];
          we_d    = i_wb_we[arb_idx];
          beat_d  = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // A beat only advances when the RF is not using the same SRAM port this cycle.
        beat_go = we_q ? !i_rf_wen : !i_rf_ren;
        wb_ren  = beat_go && !we_q;
        wb_wen  = beat_go && we_q && (|lane_sel) && !prot_hit;
        if (beat_go) begin
          if (beat_q == LAST_BEAT) state_d = we_q ? S_ACK : S_DRAIN;
          else                     beat_d  = beat_q + BWS'(1);
        end
      end
      S_DRAIN: begin
        if (cap_q) state_d = S_ACK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cap_d = wb_ren;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
    end
  end

  always_ff @(posedge i_clk) begin
    beat_q     <= beat_d;
    adr_q      <= adr_d;
    dat_q      <= dat_d;
    sel_q      <= sel_d;
    we_q       <= we_d;
    gnt_q      <= gnt_d;
    cap_beat_q <= beat_q;
    if (cap_q) rdat_q[int'(cap_beat_q)*SRAM_DW +: SRAM_DW] <= i_sram_rdata;
  end

`ifdef SUBSERVIENT_RF_PROT_EN
  localparam logic [aw-1:0] PROT_LO = aw'(depth - RF_WORDS);
  logic prot_q;
  assign prot_hit = (wb_addr >= PROT_LO);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                          prot_q <= 1'b0;
    else if (beat_go && we_q && (|lane_sel) && prot_hit) prot_q <= 1'b1;
  end
  assign o_prot_err = prot_q;
`else
  assign prot_hit   = 1'b0;
  assign o_prot_err = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < N_WB; i++) o_wb_ack[i] = (state_q == S_ACK) && (gnt_q == IW'(i));
  end

  assign o_wb_rdt = ((state_q == S_ACK) && !we_q) ? rdat_q : 32'h0;

  assign o_rf_rdata   = i_sram_rdata;
  assign o_sram_wen   = i_rf_wen | wb_wen;
  assign o_sram_waddr = i_rf_wen ? i_rf_waddr : wb_addr;
  assign o_sram_wdata = i_rf_wen ? i_rf_wdata : lane_dat;
  assign o_sram_wmask = i_rf_wen ? '1 : lane_sel;
  assign o_sram_ren   = i_rf_ren | wb_ren;
  assign o_sram_raddr = i_rf_ren ? i_rf_raddr : wb_addr;

endmodule

// File: tb/tb_subservient_mem_ctrl.sv
// Directed bench for subservient_mem_ctrl: an 8-bit-SRAM instance and a 32-bit-SRAM instance.
module tb_subservient_mem_ctrl;

`ifdef SUBSERVIENT_RF_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit SRAM instance
  logic [8:0]  rf8_waddr, rf8_raddr, s8_waddr, s8_raddr;
  logic [7:0]  rf8_wdata, rf8_rdata, s8_wdata;
  logic [7:0]  s8_rdata = 8'h0;
  logic        rf8_wen, rf8_ren, s8_wen, s8_ren, perr8;
  logic [0:0]  s8_wmask;
  logic [63:0] wb8_adr, wb8_dat;
  logic [7:0]  wb8_sel;
  logic [1:0]  wb8_we, wb8_stb, ack8;
  logic [31:0] rdt8;
  logic [7:0]  mem8 [512] = '{default: 8'h0};

  // 32-bit SRAM instance
  logic [8:0]  rf32_waddr, rf32_raddr, s32_waddr, s32_raddr;
  logic [31:0] rf32_wdata, rf32_rdata, s32_wdata;
  logic [31:0] s32_rdata = 32'h0;
  logic        rf32_wen, rf32_ren, s32_wen, s32_ren, perr32;
  logic [3:0]  s32_wmask;
  logic [63:0] wb32_adr, wb32_dat;
  logic [7:0]  wb32_sel;
  logic [1:0]  wb32_we, wb32_stb, ack32;
  logic [31:0] rdt32;
  logic [31:0] mem32 [512] = '{5: 32'hCAFEF00D, 6: 32'h55667788, default: 32'h0};

  int wen8_cnt = 0, ren8_cnt = 0, wen32_cnt = 0, ren32_cnt = 0;
  logic [3:0] lmask8 = 4'h0, lmask32 = 4'h0;

  subservient_mem_ctrl #(.depth(512), .SRAM_DW(8), .N_WB(2), .RF_WORDS(144)) dut8 (
    .i_clk(clk), .i_rst(rst),
    .i_rf_waddr(rf8_waddr), .i_rf_wdata(rf8_wdata), .i_rf_wen(rf8_wen),
    .i_rf_raddr(rf8_raddr), .i_rf_ren(rf8_ren), .o_rf_rdata(rf8_rdata),
    .i_wb_adr(wb8_adr), .i_wb_dat(wb8_dat), .i_wb_sel(wb8_sel), .i_wb_we(wb8_we),
    .i_wb_stb(wb8_stb), .o_wb_rdt(rdt8), .o_wb_ack(ack8),
    .o_sram_waddr(s8_waddr), .o_sram_wdata(s8_wdata), .o_sram_wmask(s8_wmask),
    .o_sram_wen(s8_wen), .o_sram_raddr(s8_raddr), .i_sram_rdata(s8_rdata),
    .o_sram_ren(s8_ren), .o_prot_err(perr8)
  );

  subservient_mem_ctrl #(.depth(512), .SRAM_DW(32), .N_WB(2), .RF_WORDS(144)) dut32 (
    .i_clk(clk), .i_rst(rst),
    .i_rf_waddr(rf32_waddr), .i_rf_wdata(rf32_wdata), .i_rf_wen(rf32_wen),
    .i_rf_raddr(rf32_raddr), .i_rf_ren(rf32_ren), .o_rf_rdata(rf32_rdata),
    .i_wb_adr(wb32_adr), .i_wb_dat(wb32_dat), .i_wb_sel(wb32_sel), .i_wb_we(wb32_we),
    .i_wb_stb(wb32_stb), .o_wb_rdt(rdt32), .o_wb_ack(ack32),
    .o_sram_waddr(s32_waddr), .o_sram_wdata(s32_wdata), .o_sram_wmask(s32_wmask),
    .o_sram_wen(s32_wen), .o_sram_raddr(s32_raddr), .i_sram_rdata(s32_rdata),
    .o_sram_ren(s32_ren), .o_prot_err(perr32)
  );

  // SRAM models and port activity counters
  always @(posedge clk) begin
    if (s8_ren) s8_rdata <= mem8[s8_raddr];
    if (s8_wen && s8_wmask[0]) mem8[s8_waddr] <= s8_wdata;
    if (s8_wen) begin
      wen8_cnt <= wen8_cnt + 1;
      lmask8   <= {3'b000, s8_wmask};
    end
    if (s8_ren) ren8_cnt <= ren8_cnt + 1;
    if (s32_ren) s32_rdata <= mem32[s32_raddr];
    if (s32_wen) begin
      for (int b = 0; b < 4; b++)
        if (s32_wmask[b]) mem32[s32_waddr][b*8 +: 8] <= s32_wdata[b*8 +: 8];
      wen32_cnt <= wen32_cnt + 1;
      lmask32   <= s32_wmask;
    end
    if (s32_ren) ren32_cnt <= ren32_cnt + 1;
  end

  typedef struct {
    int          dut;
    int          ch;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rdt;
    int          exp_lat;
    int          exp_wen;
    int          exp_ren;
    logic [3:0]  exp_mask;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic xfer(input int d, input int ch, input bit we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      output logic [31:0] rdt, output int lat, output logic [1:0] ackv,
                      output int nw, output int nr, output logic [3:0] lm);
    int w0, r0;
    repeat (3) @(negedge clk);
    if (d == 0) begin
      wb8_adr[ch*32 +: 32] = adr; wb8_dat[ch*32 +: 32] = dat;
      wb8_sel[ch*4 +: 4] = sel;   wb8_we[ch] = we; wb8_stb[ch] = 1'b1;
      w0 = wen8_cnt; r0 = ren8_cnt;
    end else begin
      wb32_adr[ch*32 +: 32] = adr; wb32_dat[ch*32 +: 32] = dat;
      wb32_sel[ch*4 +: 4] = sel;   wb32_we[ch] = we; wb32_stb[ch] = 1'b1;
      w0 = wen32_cnt; r0 = ren32_cnt;
    end
    lat = 0; ackv = 2'b00; rdt = 32'h0;
    while (lat < 40 && ackv == 2'b00) begin
      @(posedge clk); #1;
      lat++;
      ackv = (d == 0) ? ack8 : ack32;
      rdt  = (d == 0) ? rdt8 : rdt32;
    end
    nw = ((d == 0) ? wen8_cnt : wen32_cnt) - w0;
    nr = ((d == 0) ? ren8_cnt : ren32_cnt) - r0;
    lm = (d == 0) ? lmask8 : lmask32;
    wb8_stb = 2'b00; wb32_stb = 2'b00;
  endtask

  logic [31:0] rdt;
  logic [1:0]  ackv;
  logic [3:0]  lm;
  int          lat, nw, nr, nacks, ackerr;
  int          order [3];

  initial begin
    rf8_waddr = '0; rf8_raddr = '0; rf8_wdata = '0; rf8_wen = 1'b0; rf8_ren = 1'b0;
    rf32_waddr = '0; rf32_raddr = '0; rf32_wdata = '0; rf32_wen = 1'b0; rf32_ren = 1'b0;
    wb8_adr = '0; wb8_dat = '0; wb8_sel = '0; wb8_we = '0; wb8_stb = '0;
    wb32_adr = '0; wb32_dat = '0; wb32_sel = '0; wb32_we = '0; wb32_stb = '0;

    //            dut ch we adr           dat            sel      exp_rdt        lat wen ren  mask
    vecs[0]  = '{0, 0, 1, 32'd12,  32'hDEADBEEF, 4'b1111, 32'h0,         5, 4,  0, 4'h1};
    vecs[1]  = '{0, 0, 0, 32'd12,  32'h0,        4'b1111, 32'hDEADBEEF,  6, 0,  4, 4'h0};
    vecs[2]  = '{0, 1, 1, 32'd12,  32'h0000AB00, 4'b0010, 32'h0,         5, 1,  0, 4'h1};
    vecs[3]  = '{0, 1, 0, 32'd12,  32'h0,        4'b1111, 32'hDEADABEF,  6, 0,  4, 4'h0};
    vecs[4]  = '{0, 0, 1, 32'd16,  32'h11223344, 4'b1001, 32'h0,         5, 2,  0, 4'h1};
    vecs[5]  = '{0, 0, 0, 32'd16,  32'h0,        4'b1111, 32'h11000044,  6, 0,  4, 4'h0};
    vecs[6]  = '{0, 1, 0, 32'd524, 32'h0,        4'b1111, 32'hDEADABEF,  6, 0,  4, 4'h0};
    vecs[7]  = '{1, 0, 0, 32'd20,  32'h0,        4'b1111, 32'hCAFEF00D,  3, 0,  1, 4'h0};
    vecs[8]  = '{1, 0, 1, 32'd24,  32'hA1B2C3D4, 4'b0101, 32'h0,         2, 1,  0, 4'b0101};
    vecs[9]  = '{1, 1, 0, 32'd24,  32'h0,        4'b1111, 32'h55B277D4,  3, 0,  1, 4'h0};
    vecs[10] = '{0, 0, 1, 32'd508, 32'h01020304, 4'b1111, 32'h0,         5, PROT ? 0 : 4, 0, 4'h1};

    #12;
    check("rst_ack8", {30'h0, ack8}, 32'h0);
    check("rst_rdt8", rdt8, 32'h0);
    check("rst_perr8", {31'h0, perr8}, 32'h0);
    check("rst_ren8", {31'h0, s8_ren}, 32'h0);
    check("rst_ack32", {30'h0, ack32}, 32'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      xfer(vecs[i].dut, vecs[i].ch, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
           rdt, lat, ackv, nw, nr, lm);
      check($sformatf("v%0d_ack", i), {30'h0, ackv}, 32'(1 << vecs[i].ch));
      check($sformatf("v%0d_rdt", i), rdt, vecs[i].exp_rdt);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_wen", i), 32'(nw), 32'(vecs[i].exp_wen));
      check($sformatf("v%0d_ren", i), 32'(nr), 32'(vecs[i].exp_ren));
      if (vecs[i].exp_wen > 0) check($sformatf("v%0d_mask", i), {28'h0, lm}, {28'h0, vecs[i].exp_mask});
    end
    check("mem8_byte12", {24'h0, mem8[12]}, 32'hEF);
    check("mem8_byte13", {24'h0, mem8[13]}, 32'hAB);
    check("mem8_byte15", {24'h0, mem8[15]}, 32'hDE);
    check("mem8_byte511", {24'h0, mem8[511]}, PROT ? 32'h0 : 32'h01);
    check("prot_err_set", {31'h0, perr8}, {31'h0, PROT});
    check("prot_err_32", {31'h0, perr32}, 32'h0);

    // Reset in the middle of a read: no ack may follow, controller restarts from IDLE.
    repeat (3) @(negedge clk);
    wb8_adr[31:0] = 32'd12; wb8_we[0] = 1'b0; wb8_sel[3:0] = 4'hF; wb8_stb[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_ren", {31'h0, s8_ren}, 32'h0);
    check("midrst_perr", {31'h0, perr8}, 32'h0);
    wb8_stb = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ackerr = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ack8 != 2'b00) ackerr++;
    end
    check("midrst_noack", 32'(ackerr), 32'h0);

    // Both channels request continuously: service must alternate starting at channel 0.
    @(negedge clk);
    wb8_adr = {32'd16, 32'd12}; wb8_we = 2'b00; wb8_sel = 8'hFF; wb8_stb = 2'b11;
    nacks = 0; lat = 0;
    while (nacks < 3 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (ack8 != 2'b00) begin
        order[nacks] = (ack8 == 2'b10) ? 1 : ((ack8 == 2'b01) ? 0 : 9);
        check($sformatf("rr_rdt%0d", nacks), rdt8, (ack8 == 2'b10) ? 32'h11000044 : 32'hDEADABEF);
        nacks++;
      end
    end
    wb8_stb = 2'b00;
    check("rr_nacks", 32'(nacks), 32'd3);
    check("rr_first", 32'(order[0]), 32'd0);
    check("rr_second", 32'(order[1]), 32'd1);
    check("rr_third", 32'(order[2]), 32'd0);

    // RF read steals the SRAM read port during WB beats 1 and 2.
    repeat (3) @(negedge clk);
    wb8_adr[31:0] = 32'd12; wb8_we[0] = 1'b0; wb8_stb[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rf8_ren = 1'b1; rf8_raddr = 9'd12;
    @(posedge clk); #1;
    check("rf_rd_a", {24'h0, rf8_rdata}, 32'hEF);
    rf8_raddr = 9'd13;
    @(posedge clk); #1;
    check("rf_rd_b", {24'h0, rf8_rdata}, 32'hAB);
    rf8_ren = 1'b0;
    lat = 4; ackv = ack8;
    while (lat < 40 && ackv == 2'b00) begin
      @(posedge clk); #1;
      lat++;
      ackv = ack8; rdt = rdt8;
    end
    wb8_stb = 2'b00;
    check("rf_wb_ack", {30'h0, ackv}, 32'h1);
    check("rf_wb_lat", 32'(lat), 32'd8);
    check("rf_wb_rdt", rdt, 32'hDEADABEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/subservient_mem_ctrl.md
Name: subservient_mem_ctrl

Overview:
Multi-channel successor to the single-port subservient RAM wrapper. Shares one 1R1W SRAM macro between the SERV register-file port and N_WB Wishbone classic slave channels (ibus, dbus, debug, DMA). RF accesses always win; Wishbone channels are round-robin arbitrated and each 32-bit access is serialised into SRAM_DW-wide beats. SRAM width is generalised beyond 8 bits via a byte write mask.

Parameters:
depth, 512, SRAM depth in SRAM words; aw = $clog2(depth)
SRAM_DW, 8, SRAM word width; legal values 8, 16, 32; BEATS = 32/SRAM_DW, bw = $clog2(BEATS)
N_WB, 2, number of Wishbone slave channels (1..4); channel 0 is highest initial round-robin priority
RF_WORDS, 144, SRAM words at the top of memory reserved for the register file (used only by the optional feature)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_rf_waddr  in  aw  RF write address (SRAM word)
i_rf_wdata  in  SRAM_DW  RF write data
i_rf_wen  in  1  RF write strobe
i_rf_raddr  in  aw  RF read address
i_rf_ren  in  1  RF read strobe
o_rf_rdata  out  SRAM_DW  RF read data, valid the cycle after i_rf_ren
i_wb_adr  in  N_WB*32  per-channel byte address; bits [aw+bw-1+2-bw... i.e. aw-bw+1:2] used as word address
i_wb_dat  in  N_WB*32  per-channel write data
i_wb_sel  in  N_WB*4  per-channel byte selects
i_wb_we  in  N_WB  per-channel write enable
i_wb_stb  in  N_WB  per-channel strobe, held until ack
o_wb_rdt  out  32  shared read data, valid with any o_wb_ack bit
o_wb_ack  out  N_WB  one-cycle ack per channel, one-hot
o_sram_waddr  out  aw  SRAM write address
o_sram_wdata  out  SRAM_DW  SRAM write data
o_sram_wmask  out  SRAM_DW/8  SRAM byte write mask
o_sram_wen  out  1  SRAM write enable
o_sram_raddr  out  aw  SRAM read address
i_sram_rdata  in  SRAM_DW  SRAM read data, one cycle after o_sram_ren
o_sram_ren  out  1  SRAM read enable
o_prot_err  out  1  sticky protection error (optional feature; tied 0 otherwise)

Behaviour:
- Reset: state IDLE, rr pointer 0, o_wb_ack 0, o_wb_rdt 0, o_prot_err 0, capture flag 0. Async reset mid-access aborts it with no ack.
- RF path is combinational passthrough: i_rf_wen drives write port, i_rf_ren drives read port, o_rf_rdata = i_sram_rdata. RF wmask all ones.
- States: IDLE -> ACCESS -> DRAIN -> ACK -> IDLE.
- IDLE: pick first requesting channel at or after rr pointer; latch adr/dat/sel/we; go ACCESS. A channel acked last cycle is masked for one cycle to avoid double service.
- ACCESS: beat counter b = 0..BEATS-1; SRAM address = {word_adr, b}. Read beat issues only if i_rf_ren low; write beat only if i_rf_wen low; otherwise beat stalls, counter holds. Write beat: wen asserted only if any sel bit in that beat's lanes is set; wmask = those sel bits; a masked beat still consumes one cycle. After last beat: reads -> DRAIN, writes -> ACK.
- Capture: registered flag marks that the previous cycle issued a WB read; only then is i_sram_rdata written into lane slot of the delayed beat index. DRAIN waits for final capture.
- ACK: one-cycle o_wb_ack[grant], o_wb_rdt = assembled word (0 for writes); rr pointer = grant+1 mod N_WB.
- Uncontended latency, SRAM_DW=8: stb seen in cycle t -> read ack in t+6, write ack in t+5. SRAM_DW=32: read t+3, write t+2.
- Word address wraps modulo depth/BEATS; no bounds error.

Optional Feature:
SUBSERVIENT_RF_PROT_EN: WB writes whose SRAM address falls in [depth-RF_WORDS, depth-1] have wen suppressed for that beat, access still completes and acks normally, o_prot_err sets and holds until reset. WB reads of the region are allowed. Without the macro, no check, o_prot_err tied 0.

Decomposition:
Package subservient_mem_pkg: state enum, BEATS/bw derivation functions, legal SRAM_DW check. One sub-module: subservient_rr_arb (N_WB round-robin grant with pointer and post-ack mask).

Test Plan:
- SRAM_DW=8, ch0 write 0xDEADBEEF sel=1111 to word 3, then read -> SRAM bytes 12..15 = EF,BE,AD,DE; read ack at t+6, o_wb_rdt=0xDEADBEEF.
- Write sel=0010 data 0x0000AB00 -> only one wen pulse, byte addr+1 = 0xAB; others unchanged; ack t+5.
- ch0 and ch1 stb together continuously -> acks alternate ch0,ch1,ch0; no channel acked twice back-to-back.
- i_rf_ren high during WB read beats 1 and 2 -> RF gets correct data next cycle, WB read ack delayed 2 cycles, data still correct.
- SRAM_DW=32: read word 5 -> one o_sram_ren, ack t+3; write sel=0101 -> wmask=0101.
- Macro set: write to address depth-1 -> no wen, ack given, o_prot_err=1 until i_rst; assert i_rst mid-read -> no ack, state IDLE.
